// File: rtl/cpu_bridge_pkg.sv
package cpu_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP,
    DONE
  } bridge_state_e;

  localparam int unsigned NCH_DEF        = 2;
  localparam logic [15:0] REMAP_FROM_DEF = 16'hbfaf;
  localparam logic [15:0] REMAP_TO_DEF   = 16'h1faf;

  function automatic logic [31:0] remap_addr(input logic [31:0] addr,
                                             input logic        en,
                                             input logic [15:0] from,
                                             input logic [15:0] to);
    return (en && (addr[31:16] == from)) ? {to, addr[15:0]} : addr;
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// CPU request channels plus the AXI-lite-style master bus of cpu_mem_bridge.
interface cpu_mem_bridge_if
  import cpu_bridge_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned DW  = 32
);
  logic [NCH-1:0]        ch_req;
  logic [NCH-1:0]        ch_wr;
  logic [NCH*DW/8-1:0]   ch_wstrb;
  logic [NCH*32-1:0]     ch_addr;
  logic [NCH*DW-1:0]     ch_wdata;
  logic [NCH*DW-1:0]     ch_rdata;
  logic [NCH-1:0]        ch_done;
  logic [NCH-1:0]        ch_stall;

  logic [31:0]           m_araddr;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DW-1:0]         m_rdata;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [31:0]           m_awaddr;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [DW-1:0]         m_wdata;
  logic [DW/8-1:0]       m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic                  m_bvalid;
  logic                  m_bready;

  modport master (
    input  ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata,
    output ch_rdata, ch_done, ch_stall,
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rvalid, output m_rready,
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bvalid, output m_bready
  );

  modport slave (
    output ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata,
    input  ch_rdata, ch_done, ch_stall,
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rvalid, input m_rready,
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bvalid, input m_bready
  );

endinterface

// File: rtl/cpu_mem_bridge_arb.sv
// Fixed-priority one-hot grant; the highest requesting index wins.
module bridge_prio_arb
  import cpu_bridge_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF
) (
  input  logic [NCH-1:0] req_i,
  output logic [NCH-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: NCH-channel CPU request arbiter onto one AXI-lite-style master.
// Optional feature: CPU_BRIDGE_ADDR_REMAP_EN enables the fixed-segment address remap.
module cpu_mem_bridge
  import cpu_bridge_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned DW         = 32,
  parameter logic [15:0] REMAP_FROM = REMAP_FROM_DEF,
  parameter logic [15:0] REMAP_TO   = REMAP_TO_DEF
) (
  input logic              clk,
  input logic              resetn,
  cpu_mem_bridge_if.master bus
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef CPU_BRIDGE_ADDR_REMAP_EN
  localparam logic REMAP_EN = 1'b1;
`else
  localparam logic REMAP_EN = 1'b0;
`endif

  bridge_state_e   state_q, state_d;
  logic [NCH-1:0]  gnt, gnt_q, done;
  logic [IW-1:0]   gidx, gidx_q;
  logic            skip_q, aw_done_q, w_done_q, grant_ok;
  logic [31:0]     araddr_q, awaddr_q, addr_sel;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   rdata_q [NCH];
  logic [31:0]     addr_a  [NCH];
  logic [DW-1:0]   wdata_a [NCH];
  logic [SW-1:0]   wstrb_a [NCH];

  bridge_prio_arb #(.NCH(NCH)) u_arb (
    .req_i (bus.ch_req),
    .gnt_o (gnt)
  );

  always_comb begin
    bus.ch_rdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      addr_a[i]                   = bus.ch_addr[i*32 +: 32];
      wdata_a[i]                  = bus.ch_wdata[i*DW +: DW];
      wstrb_a[i]                  = bus.ch_wstrb[i*SW +: SW];
      bus.ch_rdata[i*DW +: DW]    = rdata_q[i];
    end
  end

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt[i]) gidx = IW'(i);
    end
  end

  // skip_q masks the IDLE cycle right after DONE so a held request is not re-served
  assign grant_ok = ~skip_q & (|bus.ch_req);
  assign addr_sel = remap_addr(addr_a[gidx], REMAP_EN, REMAP_FROM, REMAP_TO);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ok) state_d = bus.ch_wr[gidx] ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (bus.m_arready) state_d = RD_DATA;
      RD_DATA: if (bus.m_rvalid) state_d = DONE;
      WR_ADDR: if ((aw_done_q | bus.m_awready) && (w_done_q | bus.m_wready)) state_d = WR_RESP;
      WR_RESP: if (bus.m_bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done          = (state_q == DONE) ? gnt_q : '0;
    bus.ch_done   = done;
    bus.ch_stall  = bus.ch_req & ~done;
    bus.m_arvalid = (state_q == RD_ADDR);
    bus.m_rready  = (state_q == RD_DATA);
    bus.m_awvalid = (state_q == WR_ADDR) && !aw_done_q;
    bus.m_wvalid  = (state_q == WR_ADDR) && !w_done_q;
    bus.m_bready  = (state_q == WR_RESP);
    bus.m_araddr  = araddr_q;
    bus.m_awaddr  = awaddr_q;
    bus.m_wdata   = wdata_q;
    bus.m_wstrb   = wstrb_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      skip_q    <= 1'b0;
      gnt_q     <= '0;
      gidx_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int unsigned i = 0; i < NCH; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= (state_q == DONE);
      if (state_q == IDLE && grant_ok) begin
        gnt_q  <= gnt;
        gidx_q <= gidx;
        if (bus.ch_wr[gidx]) begin
          awaddr_q <= addr_sel;
          wdata_q  <= wdata_a[gidx];
          wstrb_q  <= wstrb_a[gidx];
        end else begin
          araddr_q <= addr_sel;
        end
      end
      if (state_q == WR_ADDR) begin
        aw_done_q <= aw_done_q | bus.m_awready;
        w_done_q  <= w_done_q  | bus.m_wready;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == RD_DATA && bus.m_rvalid) rdata_q[gidx_q] <= bus.m_rdata;
    end
  end

endmodule
